e_mdu: RTL and testbench

//   Multi-cycle multiply/divide unit in the E stage. Takes the E-stage rs/rt operands from the
//   D->E pipeline register and holds the architectural HI/LO registers.

---
 rtl/e_mdu.sv | 169 ++++++++++++++++
 tb/tb_e_mdu.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// e_mdu: E-stage multi-cycle multiply/divide unit holding the HI/LO registers.
// The result is computed on the accepting edge and held in a pending register;
// a countdown then models the unit latency before {HI,LO} are committed.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU (Op 6..9).
module e_mdu #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] Rs_data,
    input  logic [31:0] Rt_data,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic [3:0] {
        OP_MULT  = 4'd0,
        OP_MULTU = 4'd1,
        OP_DIV   = 4'd2,
        OP_DIVU  = 4'd3,
        OP_MTHI  = 4'd4,
        OP_MTLO  = 4'd5,
        OP_MADD  = 4'd6,
        OP_MADDU = 4'd7,
        OP_MSUB  = 4'd8,
        OP_MSUBU = 4'd9
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] MULT_COUNT = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_COUNT  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  count;
    logic [63:0] pending;
    logic        div_zero;

    // decoded operation class and computed result for the op presented this cycle
    logic        is_signed;
    logic        is_run;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic [3:0]  run_count;
    logic [63:0] next_pending;

    // datapath: shared magnitude multiplier and divider, sign fixed up afterwards
    logic        rs_neg;
    logic        rt_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [63:0] prod_mag;
    logic [63:0] product;
    logic [31:0] quo_mag;
    logic [31:0] rem_mag;
    logic [31:0] quotient;
    logic [31:0] remainder;

    // decode the incoming op into its class, latency and signedness
    always_comb begin
        is_signed = 1'b0;
        is_run    = 1'b0;
        is_div    = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        run_count = MULT_COUNT;
        case (Op)
            OP_MULT:  begin is_run = 1'b1; is_signed = 1'b1; end
            OP_MULTU: begin is_run = 1'b1; end
            OP_DIV:   begin is_run = 1'b1; is_signed = 1'b1; is_div = 1'b1; run_count = DIV_COUNT; end
            OP_DIVU:  begin is_run = 1'b1; is_div = 1'b1; run_count = DIV_COUNT; end
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD:  begin is_run = 1'b1; is_signed = 1'b1; end
            OP_MADDU: begin is_run = 1'b1; end
            OP_MSUB:  begin is_run = 1'b1; is_signed = 1'b1; end
            OP_MSUBU: begin is_run = 1'b1; end
`endif
            default: ;
        endcase
    end

    // signed ops run on magnitudes so INT_MIN / -1 wraps instead of overflowing
    always_comb begin
        rs_neg   = is_signed & Rs_data[31];
        rt_neg   = is_signed & Rt_data[31];
        a_mag    = rs_neg ? (32'd0 - Rs_data) : Rs_data;
        b_mag    = rt_neg ? (32'd0 - Rt_data) : Rt_data;
        b_safe   = (b_mag == '0) ? 32'd1 : b_mag;
        prod_mag = {32'd0, a_mag} * {32'd0, b_mag};
        product  = (rs_neg ^ rt_neg) ? (64'd0 - prod_mag) : prod_mag;
        quo_mag  = a_mag / b_safe;
        rem_mag  = a_mag % b_safe;
        quotient = (rs_neg ^ rt_neg) ? (32'd0 - quo_mag) : quo_mag;
        remainder = rs_neg ? (32'd0 - rem_mag) : rem_mag;
    end

    // select the 64-bit value that will be committed to {HI,LO}
    always_comb begin
        next_pending = product;
        case (Op)
            OP_DIV, OP_DIVU: next_pending = {remainder, quotient};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: next_pending = {HI, LO} + product;
            OP_MSUB, OP_MSUBU: next_pending = {HI, LO} - product;
`endif
            default: next_pending = product;
        endcase
    end

    // IDLE/RUN control: accept, count down, commit; Start during RUN is ignored
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            pending  <= '0;
            div_zero <= 1'b0;
            Busy     <= 1'b0;
            HI       <= '0;
            LO       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (is_mthi) begin
                            HI <= Rs_data;
                        end else if (is_mtlo) begin
                            LO <= Rs_data;
                        end else if (is_run) begin
                            pending  <= next_pending;
                            div_zero <= is_div && (Rt_data == '0);
                            count    <= run_count;
                            Busy     <= 1'b1;
                            state    <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (count <= 4'd1) begin
                        if (!div_zero) begin
                            {HI, LO} <= pending;
                        end
                        count <= '0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed test of e_mdu against a cycle-count reference model.
// The model computes results with plain 64-bit arithmetic and tracks the
// number of busy cycles remaining; a negedge process compares every cycle.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'd0;
    logic [31:0] Rs_data = 32'd0;
    logic [31:0] Rt_data = 32'd0;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int total = 0;
    int bad = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk),
        .reset(reset),
        .Start(Start),
        .Op(Op),
        .Rs_data(Rs_data),
        .Rt_data(Rt_data),
        .Busy(Busy),
        .HI(HI),
        .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model state
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;
    int          m_left = 0;
    bit          m_skip = 1'b0;
    longint      sa, sb, q, r;
    logic [63:0] ua, ub, acc;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 32'd0; m_lo = 32'd0; m_pend = 64'd0; m_left = 0; m_skip = 1'b0;
        end else if (m_left != 0) begin
            m_left--;
            if (m_left == 0 && !m_skip) {m_hi, m_lo} = m_pend;
        end else if (Start) begin
            sa = longint'($signed(Rs_data));
            sb = longint'($signed(Rt_data));
            ua = {32'd0, Rs_data};
            ub = {32'd0, Rt_data};
            acc = {m_hi, m_lo};
            m_skip = 1'b0;
            case (Op)
                4'd0: begin m_pend = sa * sb; m_left = 5; end
                4'd1: begin m_pend = ua * ub; m_left = 5; end
                4'd2, 4'd3: begin
                    m_left = 10;
                    if (Rt_data == 32'd0) m_skip = 1'b1;
                    else begin
                        if (Op == 4'd2) begin q = sa / sb; r = sa % sb; end
                        else begin q = longint'(ua) / longint'(ub); r = longint'(ua) % longint'(ub); end
                        m_pend = {r[31:0], q[31:0]};
                    end
                end
                4'd4: m_hi = Rs_data;
                4'd5: m_lo = Rs_data;
`ifdef MDU_MADD_EN
                4'd6: begin m_pend = acc + 64'(sa * sb); m_left = 5; end
                4'd7: begin m_pend = acc + ua * ub; m_left = 5; end
                4'd8: begin m_pend = acc - 64'(sa * sb); m_left = 5; end
                4'd9: begin m_pend = acc - ua * ub; m_left = 5; end
`endif
                default: ;
            endcase
        end
    end

    // per-cycle comparison against the model
    always @(negedge clk) begin
        check("busy", {31'd0, Busy}, {31'd0, m_left != 0});
        check("hi", HI, m_hi);
        check("lo", LO, m_lo);
    end

    task automatic op_cycle(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
        Start = 1'b1; Op = op; Rs_data = rs; Rt_data = rt;
        @(posedge clk); #1;
        Start = 1'b0;
        Rs_data = $urandom;
        Rt_data = $urandom;
    endtask

    task automatic wait_idle(input string name, output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        if (Busy) begin
            total++; bad++;
            $display("FAIL %s: busy still high after %0d cycles, want low", name, n);
        end
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] rs,
                          input logic [31:0] rt, input int exp_n);
        int n;
        op_cycle(op, rs, rt);
        wait_idle(name, n);
        check({name, " busy_cycles"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        check("reset busy", {31'd0, Busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);

        // async reset in the middle of a DIV
        run_op("mthi55", 4'd4, 32'h55, 32'd0, 0);
        run_op("mtlo66", 4'd5, 32'h66, 32'd0, 0);
        op_cycle(4'd2, 32'd100, 32'd7);
        repeat (6) @(posedge clk);
        #1 check("mid-div busy", {31'd0, Busy}, 32'd1);
        reset = 1'b0;
        #1;
        check("async busy", {31'd0, Busy}, 32'd0);
        check("async hi", HI, 32'd0);
        check("async lo", LO, 32'd0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 check("post-reset busy", {31'd0, Busy}, 32'd0);
        check("post-reset hi", HI, 32'd0);
        check("post-reset lo", LO, 32'd0);

        // MULT / MULTU
        run_op("mult", 4'd0, 32'hFFFFFFFE, 32'd3, 5);
        check("mult hi", HI, 32'hFFFFFFFF);
        check("mult lo", LO, 32'hFFFFFFFA);
        run_op("multu", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
        check("multu hi", HI, 32'h00000002);
        check("multu lo", LO, 32'hFFFFFFFA);

        // DIV, divide by zero, overflow wrap
        run_op("div", 4'd2, 32'hFFFFFFF9, 32'd2, 10);
        check("div lo", LO, 32'hFFFFFFFD);
        check("div hi", HI, 32'hFFFFFFFF);
        run_op("mthi11", 4'd4, 32'h11, 32'd0, 0);
        run_op("mtlo22", 4'd5, 32'h22, 32'd0, 0);
        run_op("divu0", 4'd3, 32'd7, 32'd0, 10);
        check("divu0 hi", HI, 32'h11);
        check("divu0 lo", LO, 32'h22);
        run_op("divovf", 4'd2, 32'h80000000, 32'hFFFFFFFF, 10);
        check("divovf lo", LO, 32'h80000000);
        check("divovf hi", HI, 32'h0);

        // start while busy is ignored; reissue right after busy falls
        op_cycle(4'd0, 32'd6, 32'd7);
        op_cycle(4'd2, 32'd100, 32'd3);
        wait_idle("ignore", n);
        check("ignore rest_cycles", 32'(n), 32'd4);
        check("ignore hi", HI, 32'd0);
        check("ignore lo", LO, 32'd42);
        run_op("reissue", 4'd2, 32'd100, 32'd3, 10);
        check("reissue lo", LO, 32'd33);
        check("reissue hi", HI, 32'd1);

        // MTHI / MTLO
        run_op("mthi", 4'd4, 32'hDEADBEEF, 32'd0, 0);
        check("mthi hi", HI, 32'hDEADBEEF);
        run_op("mtlo", 4'd5, 32'h12345678, 32'd0, 0);
        check("mtlo hi", HI, 32'hDEADBEEF);
        check("mtlo lo", LO, 32'h12345678);

        // accumulate ops (or no-ops without the feature)
        run_op("mthi0", 4'd4, 32'd0, 32'd0, 0);
        run_op("mtloff", 4'd5, 32'hFFFFFFFF, 32'd0, 0);
`ifdef MDU_MADD_EN
        run_op("maddu", 4'd7, 32'd1, 32'd1, 5);
        check("maddu hi", HI, 32'd1);
        check("maddu lo", LO, 32'd0);
        run_op("msub", 4'd8, 32'd2, 32'd3, 5);
        check("msub hi", HI, 32'd0);
        check("msub lo", LO, 32'hFFFFFFFA);
`else
        run_op("maddu", 4'd7, 32'd1, 32'd1, 0);
        check("maddu hi", HI, 32'd0);
        check("maddu lo", LO, 32'hFFFFFFFF);
`endif
        run_op("op12", 4'd12, 32'd5, 32'd5, 0);
        check("op12 hi", HI, m_hi);
        check("op12 lo", LO, m_lo);

        repeat (2) @(posedge clk);
        #1 $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
